// File: rtl/pwm_setpoint_loader_pkg.sv
// Shared constants and FSM encoding for the PWM setpoint loader and its period counter.
package pwm_setpoint_loader_pkg;

  localparam int TICK_COUNT_PERIOD   = 100;
  localparam int DEADTIME_HS_TO_LS   = 12;
  localparam int DEADTIME_LS_TO_HS   = 12;
  localparam int CALCULATION_TIMEOUT = 16;
  localparam int MAX_ON = TICK_COUNT_PERIOD - DEADTIME_HS_TO_LS - DEADTIME_LS_TO_HS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_ALIGN,
    ST_LOAD,
    ST_WAIT,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/pwm_setpoint_loader_period_counter.sv
// Free-running PWM period counter: counts 0..PERIOD-1 while enabled, parks at 0 otherwise.
module pwm_setpoint_loader_period_counter #(
  parameter int PERIOD = 100,
  parameter int WIDTH  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = '0;
    if (en_i && (count_q != WIDTH'(PERIOD - 1))) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pwm_setpoint_loader.sv
// Accepts duty setpoints, clamps them to the period budget and hands them to the
// half-bridge PWM stage with a period-aligned invalidate/load sequence plus watchdog.
module pwm_setpoint_loader
  import pwm_setpoint_loader_pkg::*;
#(
  parameter int tick_count_period   = TICK_COUNT_PERIOD,
  parameter int bitwidth            = $clog2(tick_count_period) + 1,
  parameter int deadtime_hs_to_ls   = DEADTIME_HS_TO_LS,
  parameter int deadtime_ls_to_hs   = DEADTIME_LS_TO_HS,
  parameter int calculation_timeout = CALCULATION_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                setpoint_valid,
  output logic                setpoint_ready,
  input  logic [bitwidth-1:0] setpoint_highside,
  input  logic [bitwidth-1:0] setpoint_lowside,
  input  logic                setpoint_dcm,
  output logic [bitwidth-1:0] tick_counter,
  output logic [bitwidth-1:0] tick_count_highside,
  output logic [bitwidth-1:0] tick_count_lowside,
  output logic                invalidate_input_values,
  output logic                load_input_values,
  input  logic                calculation_complete,
  output logic                clamped,
  output logic                timeout_error
);

  localparam int max_on = tick_count_period - deadtime_hs_to_ls - deadtime_ls_to_hs;
  localparam int AW     = bitwidth + 1;
  localparam int WDW    = $clog2(calculation_timeout + 1);

  typedef logic [AW-1:0] wide_t;

  function automatic wide_t umin(input wide_t a, input wide_t b);
    return (a < b) ? a : b;
  endfunction

  // Unsigned subtraction floored at zero instead of wrapping.
  function automatic wide_t floor_sub(input wide_t a, input wide_t b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  state_e              state_q, state_d;
  logic [bitwidth-1:0] hs_q, hs_d, ls_q, ls_d;
  logic                clamped_q, clamped_d;
  logic [WDW-1:0]      wd_q, wd_d;

  logic [bitwidth-1:0] raw_hs_q, raw_ls_q;
  logic                raw_dcm_q;
  logic [bitwidth-1:0] stg_hs_q, stg_ls_q;

  wide_t req_hs, req_ls, calc_hs, calc_ls, room;
  logic  calc_clamped;
  logic  ready_c, inval_c, load_c, accept;

  pwm_setpoint_loader_period_counter #(
    .PERIOD (tick_count_period),
    .WIDTH  (bitwidth)
  ) u_period_counter (
    .clk_i   (clock),
    .rst_ni  (reset),
    .en_i    (enable),
    .count_o (tick_counter)
  );

  assign accept = (state_q == ST_IDLE) && enable && setpoint_valid;

  always_comb begin
    req_hs       = wide_t'(raw_hs_q);
    req_ls       = wide_t'(raw_ls_q);
    calc_hs      = umin(req_hs, wide_t'(tick_count_period));
    room         = floor_sub(wide_t'(max_on), calc_hs);
    calc_ls      = raw_dcm_q ? umin(req_ls, room) : room;
    // CCM derives lowside itself, so only a highside cut counts as clamping there.
    calc_clamped = (calc_hs != req_hs) || (raw_dcm_q && (calc_ls != req_ls));
  end

  always_comb begin
    state_d   = state_q;
    hs_d      = hs_q;
    ls_d      = ls_q;
    clamped_d = clamped_q;
    wd_d      = wd_q;
    ready_c   = 1'b0;
    inval_c   = 1'b0;
    load_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_c = enable;
        if (accept) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        clamped_d = calc_clamped;
        state_d   = ST_ALIGN;
      end
      ST_ALIGN: begin
        // Tick 1 keeps the hand-off clear of the PWM stage's update window at 0 and period-1.
        if (tick_counter == bitwidth'(1)) begin
          inval_c = 1'b1;
          hs_d    = stg_hs_q;
          ls_d    = stg_ls_q;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (calculation_complete) begin
          state_d = ST_IDLE;
        end else if (wd_q == WDW'(calculation_timeout - 1)) begin
          hs_d    = '0;
          ls_d    = '0;
          state_d = ST_ERROR;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hs_q      <= '0;
      ls_q      <= '0;
      clamped_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      hs_q      <= hs_d;
      ls_q      <= ls_d;
      clamped_q <= clamped_d;
      wd_q      <= wd_d;
    end
  end

  // Capture / staging registers: data only, qualified by the FSM
  always_ff @(posedge clock) begin
    if (accept) begin
      raw_hs_q  <= setpoint_highside;
      raw_ls_q  <= setpoint_lowside;
      raw_dcm_q <= setpoint_dcm;
    end
    if (state_q == ST_COMPUTE) begin
      stg_hs_q <= bitwidth'(calc_hs);
      stg_ls_q <= bitwidth'(calc_ls);
    end
  end

  // Reset gates the decoded strobes so a reset cycle never emits a partial pulse.
  assign setpoint_ready          = ready_c & reset;
  assign invalidate_input_values = inval_c & reset;
  assign load_input_values       = load_c & reset;
  assign tick_count_highside     = hs_q;
  assign tick_count_lowside      = ls_q;
  assign clamped                 = clamped_q;
  assign timeout_error           = (state_q == ST_ERROR);

endmodule

// File: doc/pwm_setpoint_loader.md
Name: pwm_setpoint_loader

Overview:
- Upstream feeder of the half-bridge PWM stage. Owns the period tick counter and accepts duty setpoints over a valid/ready handshake.
- Derives CCM/DCM highside/lowside tick counts, clamped so that highside + lowside never exceeds the period.
- Hands the tick counts to the PWM stage with an invalidate/load pulse sequence aligned to the period, then waits for calculation_complete.
- A timeout watchdog on that handshake latches an error.

Parameters:
- tick_count_period, 100, ticks per PWM period.
- bitwidth, $clog2(tick_count_period)+1, width of all tick quantities.
- deadtime_hs_to_ls, 12, ticks.
- deadtime_ls_to_hs, 12, ticks.
- calculation_timeout, 16, maximum cycles from load pulse to calculation_complete.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low; reset==0 resets the block on the next clock edge.
- enable  in  1  run the period counter and accept setpoints.
- setpoint_valid  in  1  setpoint offered.
- setpoint_ready  out  1  setpoint accepted when valid & ready.
- setpoint_highside  in  bitwidth  requested highside on-ticks.
- setpoint_lowside  in  bitwidth  requested lowside on-ticks (DCM only).
- setpoint_dcm  in  1  1 = DCM (use setpoint_lowside), 0 = CCM (derive lowside).
- tick_counter  out  bitwidth  period counter to the PWM stage.
- tick_count_highside  out  bitwidth  to the PWM stage.
- tick_count_lowside  out  bitwidth  to the PWM stage.
- invalidate_input_values  out  1  one-cycle pulse.
- load_input_values  out  1  one-cycle pulse.
- calculation_complete  in  1  from the PWM stage.
- clamped  out  1  last accepted setpoint was modified by clamping.
- timeout_error  out  1  latched watchdog error.

Behaviour:
- **Reset (reset==0 at an edge):** all outputs, including setpoint_ready, are 0; state is IDLE.
- **Counter:** while enable=1, tick_counter counts 0..tick_count_period-1 and wraps to 0. While enable=0 it holds at 0.
- **Constants and width:** max_on = tick_count_period - deadtime_hs_to_ls - deadtime_ls_to_hs = 76. All intermediate arithmetic is bitwidth+1 wide and unsigned, with an explicit floor at 0.
- **Clamping:**
  - hs = min(setpoint_highside, tick_count_period).
  - CCM: ls = (hs >= max_on) ? 0 : max_on - hs.
  - DCM: ls = min(setpoint_lowside, (hs >= max_on) ? 0 : max_on - hs).
  - clamped = 1 if hs or ls differs from the request; in CCM, only hs is compared.
- **FSM states:**
  - IDLE: setpoint_ready = enable. On valid & ready, register the raw inputs and go to COMPUTE.
  - COMPUTE (1 cycle): register hs, ls and clamped into staging registers. Go to ALIGN.
  - ALIGN: wait until tick_counter==1, which is clear of the PWM stage's update window at ticks 0 and period-1. In that cycle:
    - drive tick_count_highside/lowside from staging;
    - pulse invalidate_input_values;
    - go to LOAD.
  - LOAD (1 cycle): pulse load_input_values, clear the watchdog, go to WAIT.
  - WAIT: on calculation_complete==1, go to IDLE. If the watchdog reaches calculation_timeout cycles first, go to ERROR.
  - ERROR:
    - timeout_error = 1;
    - tick_count_highside/lowside forced to 0;
    - setpoint_ready = 0;
    - leave only via reset. tick_counter keeps running.
- **Output timing:** tick_count_* outputs change only in the ALIGN-exit cycle (or on entering ERROR). They are stable at all other times.
- **setpoint_ready** is 0 in every state except IDLE. setpoint_valid while busy is ignored, not queued.
- **enable dropping to 0 mid-sequence:** the counter holds at 0. ALIGN therefore stalls; WAIT continues and the watchdog still runs.
- **Reset mid-sequence:** next cycle, all outputs are 0 and the state is IDLE. No partial pulses.
- **Pulses:** invalidate and load are never high in the same cycle, and each is exactly 1 cycle.

Decomposition:
- Shared pwm constants header holds:
  - FSM state localparams (IDLE, COMPUTE, ALIGN, LOAD, WAIT, ERROR);
  - max_on as a derived localparam from the deadtime parameters.
- One sub-module: period_counter (enable, wrap at tick_count_period, synchronous active-low reset), also reusable for multi-phase bridges.
- Clamping logic stays inline.

Test Plan:
1. **Reset and counter:** reset=0 for 3 cycles, then reset=1 with enable=1 -> all outputs 0 during reset; tick_counter runs 0,1,…,99,0; setpoint_ready=1.
2. **Basic CCM:** CCM, highside=40 -> lowside=36, clamped=0; invalidate pulses at tick 1, load at tick 2; calculation_complete at tick 8 -> setpoint_ready=1 at tick 9.
3. **CCM clamp:** CCM, highside=120 -> highside=100, lowside=0, clamped=1; CCM highside=90 -> lowside=0, clamped=0.
4. **DCM clamp:** DCM, highside=50, lowside=40 -> lowside=26, clamped=1; DCM 30/20 -> 30/20, clamped=0.
5. **Watchdog timeout:** calculation_complete held 0 -> 16 cycles after load, timeout_error=1, tick counts 0, ready stays 0 under further valid; reset clears it.
6. **Busy and reset mid-sequence:** setpoint_valid with new values during WAIT is ignored and outputs are unchanged. reset=0 during ALIGN -> no pulses, all outputs 0 next cycle.
